pomodoro_display: RTL and testbench
===================================

// Module: pomodoro_display
// PURPOSE
//  Pomodoro countdown timer with an 8-digit serial 7-segment display driver (2x74HC595-style chain).
//  A button selects a 5/10/15/25-minute preset; the block counts down MM:SS at 1 Hz and stops at 00:00.
//  It is the top-level timer and display block. Internal counters and digit codes are exported for verification.
// PARAMETERS
//  COUNT_LIM  27'd100_000_000  clk cycles per one-second tick; the tick period is exactly COUNT_LIM cycles (COUNT_LIM>=2)
// PORTS
//  clk                 in   1   system clock; all logic on posedge
//  rst                 in   1   synchronous, active-high reset
//  btn                 in   4   preset buttons, level, active-high: [3]=5min [2]=10min [1]=15min [0]=25min
//  sclk                out  1   serial shift clock
//  rclk                out  1   serial latch (storage) clock
//  dio                 out  1   serial data, MSB first
//  displayed_number    out  16  remaining time, packed BCD {Mt,Mu,St,Su}
//  mod_cnt             out  16  free-running display scan/shift counter
//  one_second_counter  out  27  prescaler value, 0..COUNT_LIM-1
//  LED_0..LED_7        out  4   per-digit code: 0-9 = BCD, 4'hF = blank
//  NUM_0..NUM_7        out  8   7-seg pattern of LED_n, active-low, bit7=dp (always 1), {dp,g,f,e,d,c,b,a}
// BEHAVIOUR
//  Reset: state=IDLE, displayed_number=0, one_second_counter=0, mod_cnt=0, sclk=rclk=dio=0, btn history=0.
//  Press detection: rising edge of btn[i] versus the previous-cycle register. Simultaneous edges: highest index wins.
//  Load, with one cycle of latency after the edge: displayed_number=preset (0x0500/0x1000/0x1500/0x2500).
//   Also on load: one_second_counter=0, state=RUN, preset minutes latched.
//  A press in any state, including mid-RUN, reloads immediately. rst overrides any press in the same cycle.
//  Prescaler: in RUN it increments every cycle. At COUNT_LIM-1 it wraps to 0 and asserts a one-cycle tick.
//   It holds at 0 in IDLE and DONE.
//  Tick in RUN: BCD decrement of displayed_number. Su 0->9 borrows St; St 0->5 borrows Mu; Mu 0->9 borrows Mt.
//   Example: 0x0500 -> 0x0459.
//  A tick that produces 0x0000 moves the state to DONE. DONE holds 0x0000 until a new press or rst.
//  Digit map: LED_0=Su LED_1=St LED_2=Mu LED_3=Mt, LED_4=preset-minute units, LED_5=preset-minute tens.
//   LED_6 and LED_7 are 4'hF.
//  IDLE: LED_4/LED_5 = 4'hF. DONE: LED_0..3 show 0 (see CONFIGURATION for the optional blink).
//  Decoder (NUM_n): 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90. Codes A-F give FF (blank).
//  Serial: mod_cnt increments every cycle and wraps at 16 bits. b=mod_cnt[4:1] is the bit index. d=mod_cnt[7:5] is the digit.
//   Shift word = {NUM_d, 8'b1<<d}, MSB first. dio=word[15-b].
//   sclk=mod_cnt[0], so data is stable while sclk is low and sampled on the rising edge.
//   rclk=1 when mod_cnt[4:0]==0, which latches the previous digit's complete word.
//  sclk, rclk and dio are registered: they reflect the mod_cnt value of the previous cycle.
// CONFIGURATION
//  DONE_BLINK_EN defined: in DONE a free-running prescaler toggles a blink flag every COUNT_LIM cycles.
//   While the flag is 1, LED_0..3 = 4'hF (blank). The flag resets to 0 on entering DONE.
//  DONE_BLINK_EN undefined: DONE shows a steady 00:00.
// STRUCTURE
//  pomodoro_pkg contains:
//   - the state enum IDLE/RUN/DONE
//   - the preset BCD constants (0x0500, 0x1000, 0x1500, 0x2500)
//   - the BLANK code 4'hF
//   - the 7-seg lookup table
//  One sub-module: seg7_decoder (4-bit code -> 8-bit pattern), instantiated 8 times.
//  The countdown FSM, prescaler and serializer stay in the top.
// TESTING (COUNT_LIM=2)
//  rst high 2 cycles -> displayed_number=0, LED_0..3=0, NUM_0=C0, LED_4..7=F, NUM_4..7=FF, state IDLE.
//  btn=1000 for 20 cycles -> displayed_number=0x0500 one cycle after the edge.
//   Then 0x0459 after 2 more cycles. Holding the button does not reload.
//  btn=0100 -> 0x1000. After 2 ticks press btn=1000 -> reload to 0x0500, prescaler restarts at 0.
//  Countdown from 0x0500 -> DONE after exactly 300 ticks (600 cycles). Then it holds 0x0000 with no further decrement.
//  btn=1100 in one cycle -> 5-minute preset wins. rst mid-RUN -> IDLE and 0x0000 on the next cycle.
//  Serial check: for mod_cnt[7:5]=2, collect 16 dio bits on sclk rising edges.
//   Result must equal {NUM_2,8'h04}, and rclk must pulse once per 32 cycles.

Source files
------------

// File: rtl/pomodoro_pkg.sv
// Shared types and constants for the pomodoro timer/display block.
// State encoding, preset times, blank code, 7-segment table and BCD countdown helper.
package pomodoro_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] PRESET_05 = 16'h0500;
  localparam logic [15:0] PRESET_10 = 16'h1000;
  localparam logic [15:0] PRESET_15 = 16'h1500;
  localparam logic [15:0] PRESET_25 = 16'h2500;

  localparam logic [3:0] BLANK = 4'hF;

  // Index 0 is the rightmost entry; codes A-F are blank.
  localparam logic [15:0][7:0] SEG7_LUT = {
    8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  // MM:SS BCD decrement; seconds tens borrow from 5, all other digits from 9.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (r[3:0] != 4'd0) begin
      r[3:0] = r[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (r[7:4] != 4'd0) begin
        r[7:4] = r[7:4] - 4'd1;
      end else begin
        r[7:4] = 4'd5;
        if (r[11:8] != 4'd0) begin
          r[11:8] = r[11:8] - 4'd1;
        end else begin
          r[11:8]  = 4'd9;
          r[15:12] = r[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pomodoro_display_seg7.sv
// seg7_decoder: 4-bit digit code to active-low {dp,g,f,e,d,c,b,a} pattern.
module seg7_decoder
  import pomodoro_pkg::*;
(
  input  logic [3:0] code,
  output logic [7:0] seg
);

  assign seg = SEG7_LUT[code];

endmodule

// File: rtl/pomodoro_display.sv
// Pomodoro countdown timer with 8-digit serial 7-segment driver.
// Optional macro DONE_BLINK_EN: blink the MM:SS digits once the countdown reaches 00:00.
module pomodoro_display
  import pomodoro_pkg::*;
#(
  parameter logic [26:0] COUNT_LIM = 27'd100_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  btn,
  output logic        sclk,
  output logic        rclk,
  output logic        dio,
  output logic [15:0] displayed_number,
  output logic [15:0] mod_cnt,
  output logic [26:0] one_second_counter,
  output logic [3:0]  LED_0, LED_1, LED_2, LED_3, LED_4, LED_5, LED_6, LED_7,
  output logic [7:0]  NUM_0, NUM_1, NUM_2, NUM_3, NUM_4, NUM_5, NUM_6, NUM_7
);

  state_t      state;
  logic [3:0]  btn_q;
  logic [3:0]  rise;
  logic        press;
  logic [15:0] sel_preset;
  logic [7:0]  preset_min;
  logic        tick;
  logic [15:0] dec_value;
  logic        blink;
  logic [3:0]  led [8];
  logic [7:0]  num [8];

  assign rise      = btn & ~btn_q;
  assign press     = |rise;
  assign tick      = (state == RUN) && (one_second_counter == COUNT_LIM - 27'd1);
  assign dec_value = bcd_dec(displayed_number);

  always_comb begin
    sel_preset = PRESET_25;
    if (rise[3])      sel_preset = PRESET_05;
    else if (rise[2]) sel_preset = PRESET_10;
    else if (rise[1]) sel_preset = PRESET_15;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      btn_q              <= '0;
      displayed_number   <= '0;
      preset_min         <= '0;
      one_second_counter <= '0;
    end else begin
      btn_q <= btn;
      if (press) begin
        displayed_number   <= sel_preset;
        preset_min         <= sel_preset[15:8];
        one_second_counter <= '0;
        state              <= RUN;
      end else if (state == RUN) begin
        if (tick) begin
          one_second_counter <= '0;
          displayed_number   <= dec_value;
          if (dec_value == 16'h0000) state <= DONE;
        end else begin
          one_second_counter <= one_second_counter + 27'd1;
        end
      end else begin
        one_second_counter <= '0;
      end
    end
  end

`ifdef DONE_BLINK_EN
  logic [26:0] blink_cnt;

  // Held cleared outside DONE, so every entry into DONE starts with digits visible.
  always_ff @(posedge clk) begin
    if (rst || state != DONE) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (blink_cnt == COUNT_LIM - 27'd1) begin
      blink_cnt <= '0;
      blink     <= ~blink;
    end else begin
      blink_cnt <= blink_cnt + 27'd1;
    end
  end
`else
  assign blink = 1'b0;
`endif

  always_comb begin
    led[0] = displayed_number[3:0];
    led[1] = displayed_number[7:4];
    led[2] = displayed_number[11:8];
    led[3] = displayed_number[15:12];
    if (state == DONE && blink) begin
      led[0] = BLANK;
      led[1] = BLANK;
      led[2] = BLANK;
      led[3] = BLANK;
    end
    led[4] = (state == IDLE) ? BLANK : preset_min[3:0];
    led[5] = (state == IDLE) ? BLANK : preset_min[7:4];
    led[6] = BLANK;
    led[7] = BLANK;
  end

  for (genvar g = 0; g < 8; g++) begin : g_dec
    seg7_decoder u_dec (
      .code (led[g]),
      .seg  (num[g])
    );
  end

  assign {LED_7, LED_6, LED_5, LED_4} = {led[7], led[6], led[5], led[4]};
  assign {LED_3, LED_2, LED_1, LED_0} = {led[3], led[2], led[1], led[0]};
  assign {NUM_7, NUM_6, NUM_5, NUM_4} = {num[7], num[6], num[5], num[4]};
  assign {NUM_3, NUM_2, NUM_1, NUM_0} = {num[3], num[2], num[1], num[0]};

  logic [2:0]  digit_idx;
  logic [3:0]  bit_idx;
  logic [15:0] shift_word;

  // Each digit occupies 32 scan cycles: 16 bits, two cycles per bit (sclk low, then high).
  assign digit_idx  = mod_cnt[7:5];
  assign bit_idx    = mod_cnt[4:1];
  assign shift_word = {num[digit_idx], 8'd1 << digit_idx};

  always_ff @(posedge clk) begin
    if (rst) begin
      mod_cnt <= '0;
      sclk    <= 1'b0;
      rclk    <= 1'b0;
      dio     <= 1'b0;
    end else begin
      mod_cnt <= mod_cnt + 16'd1;
      sclk    <= mod_cnt[0];
      rclk    <= (mod_cnt[4:0] == 5'd0);
      dio     <= shift_word[4'd15 - bit_idx];
    end
  end

endmodule

// File: tb/tb_pomodoro_display.sv
// Directed scoreboard bench for pomodoro_display with a two-cycle second tick.
module tb_pomodoro_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  btn;
  logic        sclk, rclk, dio;
  logic [15:0] displayed_number, mod_cnt;
  logic [26:0] one_second_counter;
  logic [3:0]  LED_0, LED_1, LED_2, LED_3, LED_4, LED_5, LED_6, LED_7;
  logic [7:0]  NUM_0, NUM_1, NUM_2, NUM_3, NUM_4, NUM_5, NUM_6, NUM_7;

  always #5 clk = ~clk;

  pomodoro_display #(.COUNT_LIM(27'd2)) dut (
    .clk(clk), .rst(rst), .btn(btn),
    .sclk(sclk), .rclk(rclk), .dio(dio),
    .displayed_number(displayed_number), .mod_cnt(mod_cnt),
    .one_second_counter(one_second_counter),
    .LED_0(LED_0), .LED_1(LED_1), .LED_2(LED_2), .LED_3(LED_3),
    .LED_4(LED_4), .LED_5(LED_5), .LED_6(LED_6), .LED_7(LED_7),
    .NUM_0(NUM_0), .NUM_1(NUM_1), .NUM_2(NUM_2), .NUM_3(NUM_3),
    .NUM_4(NUM_4), .NUM_5(NUM_5), .NUM_6(NUM_6), .NUM_7(NUM_7)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int unsigned passed = 0;
  int unsigned total  = 0;
  logic [15:0] cyc;

  always @(posedge clk) begin
    if (rst) cyc <= '0;
    else     cyc <= cyc + 16'd1;
  end

  task automatic step(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    total++;
    assert (sb.size() != 0) else begin
      $error("FAIL sb_empty: observed %h expected <none>", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) passed++;
    else $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
  endtask

  function automatic logic [15:0] time_bcd(input int unsigned secs);
    int unsigned mm, ss;
    mm = secs / 60;
    ss = secs % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic logic [7:0] seg(input logic [3:0] c);
    case (c)
      4'd0: return 8'hC0;  4'd1: return 8'hF9;  4'd2: return 8'hA4;
      4'd3: return 8'hB0;  4'd4: return 8'h99;  4'd5: return 8'h92;
      4'd6: return 8'h82;  4'd7: return 8'hF8;  4'd8: return 8'h80;
      4'd9: return 8'h90;  default: return 8'hFF;
    endcase
  endfunction

  initial begin
    logic        found, prev_sclk;
    logic [15:0] word;
    int unsigned nbits, nrclk;

    rst = 1'b1;
    btn = 4'b0000;
    step(2);
    push("rst_dn", 0);         chk(displayed_number);
    push("rst_led0", 0);       chk(LED_0);
    push("rst_num0", 8'hC0);   chk(NUM_0);
    push("rst_led4", 4'hF);    chk(LED_4);
    push("rst_num4", 8'hFF);   chk(NUM_4);
    push("rst_led7", 4'hF);    chk(LED_7);
    push("rst_num7", 8'hFF);   chk(NUM_7);
    push("rst_cnt", 0);        chk(one_second_counter);
    push("rst_mod", 0);        chk(mod_cnt);
    push("rst_ser", 0);        chk({sclk, rclk, dio});
    rst = 1'b0;
    push("mod_run", 1);        step(1); chk(mod_cnt);

    btn = 4'b1000;
    push("load5_dn", 16'h0500); step(1); chk(displayed_number);
    push("load5_cnt", 0);      chk(one_second_counter);
    push("load5_led4", 5);     chk(LED_4);
    push("load5_num4", seg(4'd5)); chk(NUM_4);
    push("load5_led5", 0);     chk(LED_5);
    push("tick1_dn", time_bcd(299)); step(2); chk(displayed_number);
    push("tick1_num0", seg(4'd9)); chk(NUM_0);
    push("hold_dn", time_bcd(291)); step(17); chk(displayed_number);

    btn = 4'b0100;
    push("load10_dn", 16'h1000); step(1); chk(displayed_number);
    push("run10_dn", time_bcd(598)); step(5); chk(displayed_number);
    push("run10_cnt", 1);      chk(one_second_counter);
    btn = 4'b1000;
    push("reload_dn", 16'h0500); push("reload_cnt", 0);
    step(1); chk(displayed_number); chk(one_second_counter);

    push("last_sec", 16'h0001); step(599); chk(displayed_number);
    push("done_dn", 0);        step(1); chk(displayed_number);
    push("done_led4", 5);      chk(LED_4);
    push("done_hold", 0);      push("done_cnt", 0);
    step(10); chk(displayed_number); chk(one_second_counter);
`ifndef DONE_BLINK_EN
    push("done_num0", 8'hC0);  chk(NUM_0);
`endif

    btn = 4'b0000; step(1);
    btn = 4'b1100;
    push("both_dn", 16'h0500); step(1); chk(displayed_number);
    push("both_led5", 0);      chk(LED_5);
    push("both_tick", time_bcd(299)); step(3); chk(displayed_number);
    rst = 1'b1;
    push("midrst_dn", 0);      push("midrst_led4", 4'hF); push("midrst_cnt", 0);
    step(1); chk(displayed_number); chk(LED_4); chk(one_second_counter);
    rst = 1'b0; btn = 4'b0000; step(1);

    btn = 4'b0001;
    push("load25_dn", 16'h2500); step(1); chk(displayed_number);
    push("load25_num5", seg(4'd2)); chk(NUM_5);
    btn = 4'b0011;
    push("load15_dn", 16'h1500); step(1); chk(displayed_number);
    push("load15_num5", seg(4'd1)); chk(NUM_5);
    push("load15_led4", 5);    chk(LED_4);

    rst = 1'b1; btn = 4'b0000; step(2); rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (cyc[7:0] == 8'h41) found = 1'b1;
      else step(1);
    end
    push("ser_sync", 1);       chk(found);
    push("ser_mod", cyc);      chk(mod_cnt);
    word = '0; nbits = 0; prev_sclk = sclk;
    for (int i = 0; i < 31; i++) begin
      step(1);
      if (sclk && !prev_sclk) begin
        word = {word[14:0], dio};
        nbits++;
      end
      prev_sclk = sclk;
    end
    push("ser_nbits", 16);     chk(nbits);
    push("ser_word", {8'hC0, 8'h04}); chk(word);
    nrclk = 0;
    for (int i = 0; i < 64; i++) begin
      step(1);
      if (rclk) nrclk++;
    end
    push("rclk_count", 2);     chk(nrclk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
